ula_sequencer: RTL and testbench

//  Instruction sequencer for the 4-bit signed ALU (ula). Accepts 8-bit micro-instructions over
//  a valid/ready handshake, holds operand registers X, Y and result register Z, drives the ALU

---
 rtl/ula_sequencer_if.sv | 31 +++
 rtl/ula_sequencer.sv | 108 ++++++++++
 tb/tb_ula_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_sequencer_if.sv
// Handshake and ALU bus between the instruction source, the sequencer and the ula.
// The slave side is the sequencer; master is the environment (instruction source plus ALU).
interface ula_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
);
  logic             instr_valid;
  logic             instr_ready;
  logic [7:0]       instr;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [OPW-1:0]   alu_op;
  logic [WIDTH-1:0] alu_res;
  logic             alu_status;
  logic [WIDTH-1:0] reg_x;
  logic [WIDTH-1:0] reg_y;
  logic [WIDTH-1:0] reg_z;
  logic             flag;
  logic             done;
  logic             halted;

  modport slave (
    input  instr_valid, instr, alu_res, alu_status,
    output instr_ready, alu_x, alu_y, alu_op, reg_x, reg_y, reg_z, flag, done, halted
  );

  modport master (
    output instr_valid, instr, alu_res, alu_status,
    input  instr_ready, alu_x, alu_y, alu_op, reg_x, reg_y, reg_z, flag, done, halted
  );
endinterface

// File: rtl/ula_sequencer.sv
// Control unit for the 4-bit signed ALU: accepts micro-instructions, drives the ALU from X/Y
// and retires each instruction through a fixed IDLE -> EXEC -> WB sequence.
module ula_sequencer #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  ula_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2,
    HALT = 2'd3
  } state_t;

  localparam logic [3:0] OP_LDX  = 4'b0001;
  localparam logic [3:0] OP_LDY  = 4'b0010;
  localparam logic [3:0] OP_MVZX = 4'b0011;
  localparam logic [3:0] OP_MVZY = 4'b0100;
  localparam logic [3:0] OP_HALT = 4'b0111;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] z_q;
  logic [OPW-1:0]   aluop_q;
  logic             flag_q;
  logic             done_q;
  logic             halted_q;
  logic             is_cmp;

  // Compare ops (equal, greater, less) report through status; every other ALU op yields a result.
  assign is_cmp = (op_q[2:0] == 3'b011) || (op_q[2:0] == 3'b100) || (op_q[2:0] == 3'b101);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= 4'b0000;
      imm_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      aluop_q  <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.instr_valid) begin
            op_q  <= bus.instr[7:4];
            imm_q <= WIDTH'($signed(bus.instr[3:0]));
            if (bus.instr[7])
              aluop_q <= OPW'(bus.instr[6:4]);
            state <= EXEC;
          end
        end
        // Writeback lands on the EXEC->WB edge so results are visible alongside done.
        EXEC: begin
          done_q <= 1'b1;
          state  <= WB;
          case (op_q)
            OP_LDX:  x_q <= imm_q;
            OP_LDY:  y_q <= imm_q;
            OP_MVZX: x_q <= z_q;
            OP_MVZY: y_q <= z_q;
            default: begin
              if (op_q[3]) begin
                if (is_cmp)
                  flag_q <= bus.alu_status;
                else
                  z_q <= bus.alu_res;
              end
            end
          endcase
        end
        WB: begin
          if (op_q == OP_HALT) begin
            halted_q <= 1'b1;
            state    <= HALT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  // Ready drops as soon as reset asserts so nothing is accepted during reset.
  assign bus.instr_ready = (state == IDLE) && !rst;
  assign bus.alu_x       = x_q;
  assign bus.alu_y       = y_q;
  assign bus.alu_op      = aluop_q;
  assign bus.reg_x       = x_q;
  assign bus.reg_y       = y_q;
  assign bus.reg_z       = z_q;
  assign bus.flag        = flag_q;
  assign bus.done        = done_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_ula_sequencer.sv
// Directed bench for ula_sequencer: a behavioural ula answers the ALU bus and a scoreboard
// of expected register state is checked at every retire.
module tb_ula_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  ula_sequencer_if #(.WIDTH(4), .OPW(3)) bus ();

  ula_sequencer #(.WIDTH(4), .OPW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ula stand-in: compare ops give status, others give a result; unused outputs carry junk.
  always_comb begin
    bus.alu_res    = 4'hF;
    bus.alu_status = 1'b1;
    case (bus.alu_op)
      3'd0: bus.alu_res    = bus.alu_x + bus.alu_y;
      3'd1: bus.alu_res    = bus.alu_x - bus.alu_y;
      3'd2: bus.alu_res    = 4'd0 - bus.alu_y;
      3'd3: bus.alu_status = (bus.alu_x == bus.alu_y);
      3'd4: bus.alu_status = ($signed(bus.alu_x) > $signed(bus.alu_y));
      3'd5: bus.alu_status = ($signed(bus.alu_x) < $signed(bus.alu_y));
      3'd6: bus.alu_res    = bus.alu_x & bus.alu_y;
      default: bus.alu_res = bus.alu_x | bus.alu_y;
    endcase
  end

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
    logic       f;
    logic [3:0] op;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0] mx = 4'd0;
  logic [3:0] my = 4'd0;
  logic [3:0] mz = 4'd0;
  logic       mf = 1'b0;
  time  acc_t = 0;
  time  prev_acc_t = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic [7:0] ins);
    logic [3:0] op;
    logic [3:0] imm;
    op  = ins[7:4];
    imm = ins[3:0];
    case (op)
      4'b0001: mx = imm;
      4'b0010: my = imm;
      4'b0011: mx = mz;
      4'b0100: my = mz;
      default: begin
        if (op[3]) begin
          case (op[2:0])
            3'd0: mz = mx + my;
            3'd1: mz = mx - my;
            3'd2: mz = 4'd0 - my;
            3'd3: mf = (mx == my);
            3'd4: mf = ($signed(mx) > $signed(my));
            3'd5: mf = ($signed(mx) < $signed(my));
            3'd6: mz = mx & my;
            default: mz = mx | my;
          endcase
        end
      end
    endcase
    sb.push_back('{mx, my, mz, mf, op});
  endtask

  // Present an instruction, wait (bounded) for the accept edge, then update the model.
  task automatic applyStimulus(input logic [7:0] ins, input bit hold);
    int n;
    n = 0;
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", {7'd0, bus.instr_ready}, 8'd1);
    @(posedge clk);
    prev_acc_t = acc_t;
    acc_t      = $time;
    modelStep(ins);
    #1;
    if (!hold) begin
      bus.instr_valid = 1'b0;
      bus.instr       = 8'($urandom);
    end
  endtask

  // Wait (bounded) for the retire pulse and compare registers with the scoreboard head.
  task automatic checkOutput();
    exp_t e;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1 && sb.size() > 0 && sb[0].op[3]) begin
        check("alu_op_exec", {5'd0, bus.alu_op}, {5'd0, sb[0].op[2:0]});
        check("alu_x_exec", {4'd0, bus.alu_x}, {4'd0, sb[0].x});
      end
    end while (!bus.done && n < 10);
    check("done_latency", 8'(n), 8'd2);
    check("ready_in_wb", {7'd0, bus.instr_ready}, 8'd0);
    check("halted_in_wb", {7'd0, bus.halted}, 8'd0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check("reg_x", {4'd0, bus.reg_x}, {4'd0, e.x});
      check("reg_y", {4'd0, bus.reg_y}, {4'd0, e.y});
      check("reg_z", {4'd0, bus.reg_z}, {4'd0, e.z});
      check("flag", {7'd0, bus.flag}, {7'd0, e.f});
    end
  endtask

  task automatic runInstr(input logic [7:0] ins);
    applyStimulus(ins, 1'b0);
    checkOutput();
  endtask

  initial begin
    int dones;
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_reg_x", {4'd0, bus.reg_x}, 8'd0);
    check("rst_reg_z", {4'd0, bus.reg_z}, 8'd0);
    check("rst_flag", {7'd0, bus.flag}, 8'd0);
    check("rst_done", {7'd0, bus.done}, 8'd0);
    check("rst_halted", {7'd0, bus.halted}, 8'd0);
    check("rst_alu_op", {5'd0, bus.alu_op}, 8'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {7'd0, bus.instr_ready}, 8'd1);

    // Wrapping add, subtract and negate.
    runInstr(8'h13);
    runInstr(8'h25);
    runInstr(8'h80);
    runInstr(8'h81);
    runInstr(8'h82);

    // Compares update only the flag.
    runInstr(8'h12);
    runInstr(8'h22);
    runInstr(8'h83);
    runInstr(8'h27);
    runInstr(8'h85);
    runInstr(8'h84);

    // Overflow wrap, moves from Z, negative immediate, bitwise op, NOP.
    runInstr(8'h17);
    runInstr(8'h21);
    runInstr(8'h80);
    runInstr(8'h30);
    runInstr(8'h40);
    runInstr(8'h18);
    runInstr(8'h23);
    runInstr(8'h87);
    runInstr(8'h05);

    // Back-to-back with valid held high; the changed instr while busy must be ignored.
    applyStimulus(8'h11, 1'b1);
    bus.instr = 8'h12;
    checkOutput();
    applyStimulus(8'h12, 1'b0);
    check("b2b_spacing", 8'((acc_t - prev_acc_t) / 10), 8'd3);
    checkOutput();

    // HALT is terminal until reset.
    runInstr(8'h70);
    @(negedge clk);
    check("halted", {7'd0, bus.halted}, 8'd1);
    check("halt_ready", {7'd0, bus.instr_ready}, 8'd0);
    bus.instr       = 8'h15;
    bus.instr_valid = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    bus.instr_valid = 1'b0;
    check("halt_no_done", 8'(dones), 8'd0);
    check("halt_reg_x", {4'd0, bus.reg_x}, {4'd0, mx});

    // Reset out of HALT, then reset again in the middle of an add.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    mx = 4'd0; my = 4'd0; mz = 4'd0; mf = 1'b0;
    @(negedge clk);
    check("unhalt_ready", {7'd0, bus.instr_ready}, 8'd1);
    runInstr(8'h13);
    runInstr(8'h25);
    applyStimulus(8'h80, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_reg_x", {4'd0, bus.reg_x}, 8'd0);
    check("midrst_reg_y", {4'd0, bus.reg_y}, 8'd0);
    check("midrst_reg_z", {4'd0, bus.reg_z}, 8'd0);
    check("midrst_alu_x", {4'd0, bus.alu_x}, 8'd0);
    check("midrst_done", {7'd0, bus.done}, 8'd0);
    check("midrst_ready", {7'd0, bus.instr_ready}, 8'd0);
    sb.delete();
    mx = 4'd0; my = 4'd0; mz = 4'd0; mf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_ready", {7'd0, bus.instr_ready}, 8'd1);
    dones = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("postrst_no_done", 8'(dones), 8'd0);
    runInstr(8'h14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
